muldiv_unit: RTL

- Parametrised iterative multiply/divide unit that owns the HI/LO register pair.
- Successor to the multiplier-only wrapper on the fast clock; adds signed and unsigned divide, a configurable number of bits retired per cycle, abort-on-restart, and divide-by-zero reporting.
- Driven by stage_ex (start, operands) and stage_mem (HI/LO writes, ready polling for stall).

---
 rtl/muldiv_unit_pkg.sv | 20 ++
 rtl/muldiv_unit_step.sv | 44 ++++
 rtl/muldiv_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, HI/LO write codes and FSM encodings for the mul/div unit.
package muldiv_unit_pkg;

  localparam int MULDIV_OP_WIDTH = 2;
  localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_MULTU = 2'b00;
  localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_MULT  = 2'b01;
  localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_DIVU  = 2'b10;
  localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_DIV   = 2'b11;

  localparam int LOHI_WRITE_OPT_WIDTH = 2;
  localparam logic [LOHI_WRITE_OPT_WIDTH-1:0] LOHI_WRITE_NONE = 2'b00;
  localparam logic [LOHI_WRITE_OPT_WIDTH-1:0] LOHI_WRITE_LO   = 2'b01;
  localparam logic [LOHI_WRITE_OPT_WIDTH-1:0] LOHI_WRITE_HI   = 2'b10;
  localparam logic [LOHI_WRITE_OPT_WIDTH-1:0] LOHI_WRITE_RSVD = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_unit_step.sv
// One UNROLL-bit iteration: shift-add multiply or restoring divide.
// Mul: hi = partial product, lo = multiplier shifting out, b = multiplicand.
// Div: hi = partial remainder, lo = dividend shifting out / quotient in, b = divisor.
module muldiv_unit_step #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH-1:0] w_h;
  logic [WIDTH-1:0] w_l;
  logic [WIDTH:0]   w_t;

  // Retire UNROLL bits; w_t carries the adder carry-out / trial-subtract bit.
  always_comb begin
    w_h = i_hi;
    w_l = i_lo;
    w_t = '0;
    for (int k = 0; k < UNROLL; k++) begin
      if (i_is_div) begin
        w_t = {w_h, w_l[WIDTH-1]};
        w_l = {w_l[WIDTH-2:0], 1'b0};
        if (w_t >= {1'b0, i_b}) begin
          w_t    = w_t - {1'b0, i_b};
          w_l[0] = 1'b1;
        end
        w_h = w_t[WIDTH-1:0];
      end else begin
        w_t = {1'b0, w_h} + (w_l[0] ? {1'b0, i_b} : {(WIDTH+1){1'b0}});
        w_l = {w_t[0], w_l[WIDTH-1:1]};
        w_h = w_t[WIDTH:1];
      end
    end
    o_hi = w_h;
    o_lo = w_l;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair.
// Operands are reduced to magnitudes on entry; signs are reapplied in FIX.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [MULDIV_OP_WIDTH-1:0]      op,
  input  logic [WIDTH-1:0]                opr1,
  input  logic [WIDTH-1:0]                opr2,
  input  logic [LOHI_WRITE_OPT_WIDTH-1:0] write_opt,
  input  logic [WIDTH-1:0]                write_data,
  output logic [2*WIDTH-1:0]              result,
  output logic                            ready,
  output logic                            div_by_zero
);

  localparam int N  = WIDTH / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % UNROLL) != 0) begin : g_bad_unroll
    $error("muldiv_unit: UNROLL must divide WIDTH");
  end

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_neg_q;     // product sign for mul, quotient sign for div
  logic             r_neg_r;     // remainder sign (dividend sign)
  logic             r_dz;
  logic [WIDTH-1:0] r_dividend;  // raw opr1, returned in HI on divide by zero
  logic [WIDTH-1:0] r_wh;
  logic [WIDTH-1:0] r_wl;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dbz;

  logic               w_s1, w_s2;
  logic [WIDTH-1:0]   w_mag1, w_mag2;
  logic               w_wr_lo, w_wr_hi, w_wr;
  logic [WIDTH-1:0]   w_step_hi, w_step_lo;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic               w_commit;

  assign w_s1    = op[0] & opr1[WIDTH-1];
  assign w_s2    = op[0] & opr2[WIDTH-1];
  assign w_mag1  = w_s1 ? -opr1 : opr1;
  assign w_mag2  = w_s2 ? -opr2 : opr2;
  assign w_wr_lo = (write_opt == LOHI_WRITE_LO);
  assign w_wr_hi = (write_opt == LOHI_WRITE_HI);
  assign w_wr    = w_wr_lo | w_wr_hi;

  assign w_prod     = {r_wh, r_wl};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo      = r_neg_q ? -r_wl : r_wl;
  assign w_rem      = r_neg_r ? -r_wh : r_wh;
  assign w_commit   = (r_state == S_FIX) && !w_wr && !start;

  muldiv_unit_step #(.WIDTH(WIDTH), .UNROLL(UNROLL)) u_step (
    .i_is_div (r_is_div),
    .i_hi     (r_wh),
    .i_lo     (r_wl),
    .i_b      (r_b),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo)
  );

  // FSM and working registers; a write aborts, otherwise start (re)launches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_dividend <= '0;
      r_wh       <= '0;
      r_wl       <= '0;
      r_b        <= '0;
    end else if (w_wr) begin
      r_state <= S_IDLE;
    end else if (start) begin
      r_state    <= S_CALC;
      r_cnt      <= CW'(N - 1);
      r_is_div   <= op[1];
      r_neg_q    <= w_s1 ^ w_s2;
      r_neg_r    <= w_s1;
      r_dz       <= op[1] & (opr2 == '0);
      r_dividend <= opr1;
      r_wh       <= '0;
      r_wl       <= op[1] ? w_mag1 : w_mag2;
      r_b        <= op[1] ? w_mag2 : w_mag1;
    end else begin
      case (r_state)
        S_CALC: begin
          r_wh <= w_step_hi;
          r_wl <= w_step_lo;
          if (r_cnt == '0) r_state <= S_FIX;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_FIX:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // HI/LO only change on an explicit write or at commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_dbz <= 1'b0;
    end else if (w_wr) begin
      if (w_wr_lo) r_lo <= write_data;
      if (w_wr_hi) r_hi <= write_data;
    end else if (w_commit) begin
      r_dbz <= r_dz;
      if (r_dz) begin
        r_lo <= '1;
        r_hi <= r_dividend;
      end else if (r_is_div) begin
        r_lo <= w_quo;
        r_hi <= w_rem;
      end else begin
        {r_hi, r_lo} <= w_prod_fix;
      end
    end
  end

  assign result      = {r_hi, r_lo};
  assign ready       = (r_state == S_IDLE);
  assign div_by_zero = r_dbz;

endmodule
